logic_vec_gen: RTL and testbench
================================

# logic_vec_gen

Sequential stimulus source directly upstream of the bitwise/logical-operator stage. It produces the 8-bit operand vector that stage consumes, one vector per valid/ready beat, in one of four deterministic sequences. It signals completion so a checker can close out the run. It replaces free-running testbench stimulus with a synthesizable, reproducible generator.

## Interface
Parameters:
- WIDTH, 8, vector width. The consumer expects 8.
- LFSR_SEED, 8'hA5, LFSR start value. A zero seed is replaced by 1.
- LFSR_TAPS, 8'hB8, Galois feedback mask (x^8+x^6+x^5+x^4+1).

Ports:
- clk, input, 1, sole clock. All logic is on the rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, begin a run. Sampled only in IDLE.
- mode, input, 2, sequence select. Latched on an accepted start.
- out_vec, output, [0:WIDTH-1], operand vector. Ascending index; out_vec[0] is the value MSB.
- out_valid, output, 1, out_vec holds a vector.
- out_ready, input, 1, consumer accepts the vector this cycle.
- busy, output, 1, high in RUN.
- done, output, 1, one-cycle pulse after the last vector is accepted.
- count, output, WIDTH+1, number of vectors accepted in the current or last run.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, with start=1: latch mode, load the first vector, clear count, go to RUN.
- RUN, on a beat (out_valid && out_ready): count+1. If this was the last vector, go to DONE; otherwise advance to the next vector.
- DONE: done=1 for exactly one cycle, then IDLE.
- Modes:
  - 0, counter: values 0..2^WIDTH-1 ascending, 256 vectors. No wrap; the run ends at 8'hFF.
  - 1, walking-one: vector k has only out_vec[k]=1, k=0..WIDTH-1. 8 vectors: 8'h80, 8'h40, …, 8'h01.
  - 2, LFSR: first vector is the seed. next = (v>>1) ^ (v[0] ? LFSR_TAPS : 0). 255 vectors, ending on the state before the seed recurs.
  - 3, toggle: 8'h00 then 8'hFF. 2 vectors.
- start in RUN or DONE is ignored. mode changes outside an accepted start are ignored.
- Values and counter arithmetic are WIDTH-bit, unsigned. count is WIDTH+1 bits so that 256 fits.
- Reset, including mid-run: state=IDLE, out_vec=0, out_valid=0, busy=0, done=0, count=0. The next cycle behaves as fresh IDLE.

## Timing
- An accepted start in cycle n gives out_valid=1 with the first vector in cycle n+1. busy=1 from n+1.
- One vector per cycle while out_ready is held high. Zero bubbles between vectors.
- Handshake: with out_valid=1 and out_ready=0, out_vec stays unchanged and out_valid stays high. out_valid never drops without a beat.
- Last beat in cycle m: in cycle m+1, out_valid=0, busy=0, done=1, and count holds the final value. In cycle m+2 the block is in IDLE and a new start is accepted.
- count holds its value in IDLE until the next accepted start.
- out_ready is ignored when out_valid=0.
- start=1 in the same cycle as the done pulse is ignored.

## Structure
- Package logic_vec_gen_pkg:
  - mode_e: MODE_CNT, MODE_WALK, MODE_LFSR, MODE_TOG.
  - state_e: IDLE, RUN, DONE.
  - Default seed and taps constants.
  - Per-mode vector-count function.
- Sub-module lfsr_step: a combinational Galois next-state function, parameterized by WIDTH and TAPS, reusable by the consumer-side checker.
- The top module holds the FSM, vector register, counter, and mode latch.

## Test plan
- Mode 0, out_ready=1, start at cycle 0: vectors 8'h00..8'hFF on cycles 1..256. done=1 at cycle 257. count=256.
- Mode 1 with out_ready toggling 1,0,1,0: exactly 8 beats of 80,40,20,10,08,04,02,01. Data stays stable during every stall. done follows the 8th beat.
- Mode 2, default seed and taps: first four vectors A5, EA, 75, 82. 255 beats total with no repeats. The final vector feeds back to A5 through lfsr_step.
- Mode 3: 00 then FF, count=2. A start pulsed during RUN and on the done cycle has no effect; the run is not restarted.
- Reset at beat 100 of mode 0: the next cycle shows out_valid=0, count=0, IDLE. A start issued then begins again at 8'h00.
- LFSR_SEED=0 override: the first vector is 8'h01 and the run still produces 255 vectors.

Source files
------------

// File: rtl/logic_vec_gen_pkg.sv
// logic_vec_gen_pkg
// Shared types and constants for the operand-vector generator and its
// consumer-side checker.
//   mode_e      : sequence select (counter, walking-one, LFSR, toggle)
//   state_e     : generator FSM states
//   DEFAULT_*   : default LFSR seed and Galois feedback mask
//   vec_count() : number of vectors a run of a given mode produces
package logic_vec_gen_pkg;

    typedef enum logic [1:0] {
        MODE_CNT  = 2'd0,
        MODE_WALK = 2'd1,
        MODE_LFSR = 2'd2,
        MODE_TOG  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] DEFAULT_SEED = 8'hA5;
    // x^8 + x^6 + x^5 + x^4 + 1, maximal length (255 states)
    localparam logic [7:0] DEFAULT_TAPS = 8'hB8;

    function automatic int vec_count(mode_e m, int width);
        int n;
        case (m)
            MODE_CNT:  n = 1 << width;
            MODE_WALK: n = width;
            MODE_LFSR: n = (1 << width) - 1;
            MODE_TOG:  n = 2;
            default:   n = 2;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/logic_vec_gen_if.sv
// logic_vec_gen_if
// Valid/ready stream carrying one operand vector per beat.
//   out_vec   : operand vector, ascending index, out_vec[0] is the value MSB
//   out_valid : out_vec holds a vector
//   out_ready : consumer accepts the vector this cycle
// master = generator side, slave = consumer side.
interface logic_vec_gen_if #(
    parameter int WIDTH = 8
);
    logic [0:WIDTH-1] out_vec;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_vec,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_vec,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/logic_vec_gen_lfsr_step.sv
// lfsr_step
// Combinational Galois LFSR next-state function, shared with the
// consumer-side checker so both ends agree on the sequence.
//   state_i : current LFSR state
//   next_o  : (state_i >> 1) ^ (state_i[0] ? TAPS : 0)
module lfsr_step
    import logic_vec_gen_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS)
) (
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] next_o
);

    assign next_o = (state_i >> 1) ^ (state_i[0] ? TAPS : '0);

endmodule

// File: rtl/logic_vec_gen.sv
// logic_vec_gen
// Synthesizable operand-vector source feeding the bitwise/logical stage.
// A run emits one of four deterministic sequences over a valid/ready stream
// and pulses done after the last beat.
//   clk, rst : clock, synchronous active-high reset
//   start    : begin a run (sampled in IDLE only)
//   mode     : sequence select, latched on an accepted start
//   vec_if   : stream master (out_vec / out_valid / out_ready)
//   busy     : high while a run is in progress
//   done     : one-cycle pulse after the last accepted vector
//   count    : vectors accepted in the current or last run
//
// state | meaning
// IDLE  | waiting for start; count holds the last run's total
// RUN   | presenting vectors, advancing on each beat
// DONE  | done pulse for one cycle, start ignored
module logic_vec_gen
    import logic_vec_gen_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] LFSR_SEED = WIDTH'(DEFAULT_SEED),
    parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(DEFAULT_TAPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           mode,
    logic_vec_gen_if.master      vec_if,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH:0]       count
);

    localparam int CW = WIDTH + 1;
    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [WIDTH-1:0] SEED_EFF = (LFSR_SEED == '0) ? WIDTH'(1) : LFSR_SEED;

    state_e           state_q;
    mode_e            mode_q;
    logic [WIDTH-1:0] vec_q;
    logic [WIDTH:0]   cnt_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] vec_d;
    logic [WIDTH-1:0] first_vec;
    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH:0]   total;
    logic             beat;
    logic             last_beat;

    lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (LFSR_TAPS)
    ) u_lfsr_step (
        .state_i (vec_q),
        .next_o  (lfsr_next)
    );

    always_comb begin
        first_vec = '0;
        case (mode_e'(mode))
            MODE_CNT:  first_vec = '0;
            MODE_WALK: first_vec = {1'b1, {(WIDTH-1){1'b0}}};
            MODE_LFSR: first_vec = SEED_EFF;
            MODE_TOG:  first_vec = '0;
            default:   first_vec = '0;
        endcase
    end

    always_comb begin
        vec_d = vec_q;
        case (mode_q)
            MODE_CNT:  vec_d = vec_q + 1'b1;
            MODE_WALK: vec_d = vec_q >> 1;
            MODE_LFSR: vec_d = lfsr_next;
            MODE_TOG:  vec_d = ~vec_q;
            default:   vec_d = vec_q;
        endcase
    end

    // The run length is fixed by the latched mode, so the last beat is simply
    // the one that brings the accepted count up to that length.
    assign total     = CW'(vec_count(mode_q, WIDTH));
    assign beat      = valid_q && vec_if.out_ready;
    assign last_beat = beat && ((cnt_q + 1'b1) == total);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_CNT;
            vec_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mode_q  <= mode_e'(mode);
                        vec_q   <= first_vec;
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (beat) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last_beat) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            vec_q <= vec_d;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign vec_if.out_vec   = vec_q;
    assign vec_if.out_valid = valid_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign count            = cnt_q;

endmodule

// File: tb/tb_logic_vec_gen.sv
// tb_logic_vec_gen
// Table-driven runs of every mode under several out_ready patterns, each
// checked beat by beat against a sequence list built from the mode rules,
// plus hand sequences for reset mid-run and the zero-seed override.
module tb_logic_vec_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic       ready;

    logic_vec_gen_if #(.WIDTH(8)) if0 ();
    logic_vec_gen_if #(.WIDTH(8)) if1 ();

    assign if0.out_ready = ready;
    assign if1.out_ready = ready;

    logic       busy0, busy1, done0, done1;
    logic [8:0] cnt0, cnt1;

    logic_vec_gen #(.WIDTH(8)) dut0 (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .vec_if (if0),
        .busy   (busy0),
        .done   (done0),
        .count  (cnt0)
    );

    logic_vec_gen #(.WIDTH(8), .LFSR_SEED(8'h00)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .vec_if (if1),
        .busy   (busy1),
        .done   (done1),
        .count  (cnt1)
    );

    logic [7:0] fb_in, fb_out;
    lfsr_step #(.WIDTH(8), .TAPS(8'hB8)) u_fb (
        .state_i (fb_in),
        .next_o  (fb_out)
    );

    // observed DUT (0 = default seed, 1 = zero seed)
    int         cur;
    logic [7:0] s_vec;
    logic       s_valid, s_busy, s_done;
    logic [8:0] s_cnt;
    logic [7:0] v0, v1;
    assign v0 = if0.out_vec;
    assign v1 = if1.out_vec;

    always_comb begin
        s_vec   = v0;
        s_valid = if0.out_valid;
        s_busy  = busy0;
        s_done  = done0;
        s_cnt   = cnt0;
        if (cur == 1) begin
            s_vec   = v1;
            s_valid = if1.out_valid;
            s_busy  = busy1;
            s_done  = done1;
            s_cnt   = cnt1;
        end
    end

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] head [4];

    typedef struct {
        int         sel;
        int         m;
        int         rdy;   // 0 always ready, 1 alternating, 2 random
        bit         noise; // random start/mode while running and on done
        logic [7:0] first;
        int         n;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference sequences straight from the mode definitions.
    task automatic build(int m, logic [7:0] seed);
        int v, s0;
        exp_q.delete();
        case (m)
            0: for (int i = 0; i < 256; i++) exp_q.push_back(8'(i));
            1: for (int k = 0; k < 8; k++) exp_q.push_back(8'(1 << (7 - k)));
            2: begin
                v  = (seed == 0) ? 1 : int'(seed);
                s0 = v;
                do begin
                    exp_q.push_back(8'(v));
                    v = (v / 2) ^ (((v % 2) == 1) ? 'hB8 : 0);
                end while (v != s0 && exp_q.size() < 300);
            end
            default: begin
                exp_q.push_back(8'h00);
                exp_q.push_back(8'hFF);
            end
        endcase
    endtask

    task automatic run(vec_t t);
        int         idx = 0;
        int         cyc = 0;
        logic [7:0] lastv = 8'h00;
        cur = t.sel;
        build(t.m, (t.sel == 1) ? 8'h00 : 8'hA5);
        chk("idle_valid", 32'(s_valid), 0);
        mode  = 2'(t.m);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("first_vec", 32'(s_vec), 32'(t.first));
        chk("busy_rise", 32'(s_busy), 1);
        while (idx < t.n && cyc < 2000) begin
            chk("valid_hold", 32'(s_valid), 1);
            if (idx < exp_q.size()) chk("vec", 32'(s_vec), 32'(exp_q[idx]));
            chk("count_run", 32'(s_cnt), 32'(idx));
            if (t.sel == 0 && t.m == 2 && idx < 4) chk("lfsr_head", 32'(s_vec), 32'(head[idx]));
            if (t.sel == 0 && t.m == 1 && idx == 0) chk("msb_index0", 32'(if0.out_vec[0]), 1);
            case (t.rdy)
                0:       ready = 1'b1;
                1:       ready = (cyc % 2) == 0;
                default: ready = 1'($urandom_range(0, 1));
            endcase
            if (t.noise) begin
                start = 1'($urandom_range(0, 1));
                mode  = 2'($urandom_range(0, 3));
            end
            if (ready) begin
                lastv = s_vec;
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("beats_in_budget", 32'(idx), 32'(t.n));
        // cycle after the last beat
        chk("end_valid", 32'(s_valid), 0);
        chk("end_busy", 32'(s_busy), 0);
        chk("end_done", 32'(s_done), 1);
        chk("end_count", 32'(s_cnt), 32'(t.n));
        start = t.noise;
        @(negedge clk);
        start = 1'b0;
        ready = 1'b0;
        chk("post_done", 32'(s_done), 0);
        chk("post_valid", 32'(s_valid), 0);
        chk("post_busy", 32'(s_busy), 0);
        chk("count_hold", 32'(s_cnt), 32'(t.n));
        if (t.m == 2) begin
            fb_in = lastv;
            #1;
            chk("lfsr_wrap", 32'(fb_out), (t.sel == 1) ? 32'h01 : 32'hA5);
        end
        @(negedge clk);
    endtask

    initial begin
        head[0] = 8'hA5; head[1] = 8'hEA; head[2] = 8'h75; head[3] = 8'h82;
        tbl[0] = '{0, 0, 0, 1'b0, 8'h00, 256};
        tbl[1] = '{0, 1, 1, 1'b0, 8'h80, 8};
        tbl[2] = '{0, 2, 0, 1'b0, 8'hA5, 255};
        tbl[3] = '{0, 3, 0, 1'b1, 8'h00, 2};
        tbl[4] = '{1, 2, 2, 1'b0, 8'h01, 255};
        tbl[5] = '{0, 1, 2, 1'b1, 8'h80, 8};
        tbl[6] = '{0, 3, 2, 1'b0, 8'h00, 2};
        tbl[7] = '{0, 2, 2, 1'b1, 8'hA5, 255};

        cur   = 0;
        fb_in = 8'h00;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 2'd0;
        ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(if0.out_valid), 0);
        chk("rst_vec", 32'(v0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_count", 32'(cnt0), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run(tbl[i]);

        // reset at beat 100 of a counter run, then a clean restart
        cur   = 0;
        mode  = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            chk("pre_rst_vec", 32'(v0), 32'(i));
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid", 32'(if0.out_valid), 0);
        chk("midrst_count", 32'(cnt0), 0);
        chk("midrst_busy", 32'(busy0), 0);
        chk("midrst_vec", 32'(v0), 0);
        ready = 1'b0;
        run(tbl[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
